// File: rtl/cpu_player.sv
// cpu_player: computer-controlled Tug of War opponent producing a synthetic active-low key.
// Optional macro CPU_PLAYER_TICK_EN: decisions, LFSR steps and hold/gap counts advance on a prescaled tick.
module cpu_player #(
   parameter int HOLD_CYC = 2,
   parameter int GAP_CYC  = 2,
   parameter int TICK_W   = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic [8:0] difficulty,
   output logic       key_n,
   output logic       press_pulse,
   output logic [9:0] lfsr_q
);
   localparam int CMAX = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
   localparam int CW = $clog2(CMAX + 1);

   typedef enum logic [1:0] {IDLE, PRESS, RELEASE} state_t;

   state_t state, state_d;
   logic [CW-1:0] cnt, cnt_d;
   logic key_d, pulse_d, press_req, tick;

`ifdef CPU_PLAYER_TICK_EN
   logic [TICK_W-1:0] pre;
   assign tick = &pre;
   // free-running prescaler; the tick marks its wrap back to zero
   always_ff @(posedge clk or posedge reset)
      if (reset) pre <= '0;
      else pre <= pre + 1'b1;
`else
   // without the prescaler every clock is a tick (TICK_W is always positive)
   assign tick = TICK_W > 0;
`endif

   // XNOR LFSR; all-ones lockup is unreachable from zero
   always_ff @(posedge clk or posedge reset)
      if (reset) lfsr_q <= '0;
      else if (tick) lfsr_q <= {lfsr_q[8:0], ~(lfsr_q[9] ^ lfsr_q[6])};

   assign press_req = enable && ({1'b0, difficulty} > lfsr_q);

   // state, counter and registered outputs
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         key_n       <= 1'b1;
         press_pulse <= 1'b0;
      end else begin
         state       <= state_d;
         cnt         <= cnt_d;
         key_n       <= key_d;
         press_pulse <= pulse_d;
      end

   // press/hold/release sequencing; an enable drop aborts only an active press
   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      key_d   = 1'b1;
      pulse_d = 1'b0;
      case (state)
         IDLE:
            if (tick && press_req) begin
               state_d = PRESS;
               key_d   = 1'b0;
               pulse_d = 1'b1;
               cnt_d   = CW'(HOLD_CYC - 1);
            end
         PRESS:
            if (!enable) state_d = IDLE;
            else if (!tick) key_d = 1'b0;
            else if (cnt == '0) begin
               state_d = RELEASE;
               cnt_d   = CW'(GAP_CYC - 1);
            end else begin
               key_d = 1'b0;
               cnt_d = cnt - 1'b1;
            end
         RELEASE:
            if (tick) begin
               if (cnt == '0) state_d = IDLE;
               else cnt_d = cnt - 1'b1;
            end
         default: state_d = IDLE;
      endcase
   end
endmodule

// File: tb/tb_cpu_player.sv
// tb_cpu_player: randomized self-checking bench for cpu_player against a duration-based reference model.
module tb_cpu_player;
   localparam int HOLD = 2;
   localparam int GAP  = 2;

   logic clk = 0, reset = 1, enable = 0;
   logic [8:0] difficulty = '0;
   logic key_n, press_pulse;
   logic [9:0] lfsr_q;

   int n_vec = 0, n_bad = 0;

   // reference model: key is low for a number of remaining cycles, then blocked for a gap
   logic [9:0] m_lfsr;
   logic m_key, m_pulse;
   int low_left, block_left;

   // run-length tracking for the long constant-difficulty phase
   int run_len, low_runs, pulses;
   logic prev_key, seen_low;

   cpu_player #(.HOLD_CYC(HOLD), .GAP_CYC(GAP), .TICK_W(4)) dut (
      .clk(clk), .reset(reset), .enable(enable), .difficulty(difficulty),
      .key_n(key_n), .press_pulse(press_pulse), .lfsr_q(lfsr_q)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [9:0] lfsr_next(input logic [9:0] q);
      return {q[8:0], ~(q[9] ^ q[6])};
   endfunction

   task automatic model_reset();
      m_lfsr = '0; m_key = 1; m_pulse = 0; low_left = 0; block_left = 0;
   endtask

   // one clock edge of the model, using the values sampled just before it
   task automatic model_edge(input logic en, input logic [8:0] d);
      logic [9:0] cur;
      cur = m_lfsr;
      m_lfsr = lfsr_next(m_lfsr);
      m_pulse = 0;
      if (low_left > 0) begin
         if (!en) begin
            low_left = 0; block_left = 0; m_key = 1;
         end else begin
            low_left--;
            if (low_left == 0) begin m_key = 1; block_left = GAP; end
         end
      end else if (block_left > 0) begin
         block_left--;
      end else if (en && ({1'b0, d} > cur)) begin
         m_key = 0; m_pulse = 1; low_left = HOLD;
      end
   endtask

   task automatic step(input logic en, input logic [8:0] d);
      enable = en; difficulty = d;
      @(posedge clk);
      model_edge(en, d);
      @(negedge clk);
      chk("key_n", key_n, m_key);
      chk("press_pulse", press_pulse, m_pulse);
      chk("lfsr_q", lfsr_q, m_lfsr);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1;
      #1;
      model_reset();
      @(negedge clk);
      reset = 0;
   endtask

   logic [9:0] seq [8] = '{10'd1, 10'd3, 10'd7, 10'd15, 10'd31, 10'd63, 10'd127, 10'd254};

   initial begin
      model_reset();
      #12;
      chk("rst_key_n", key_n, 1);
      chk("rst_pulse", press_pulse, 0);
      chk("rst_lfsr", lfsr_q, 0);

      // full difficulty from reset release: press on the first edge
      difficulty = 9'd511; enable = 1;
      @(negedge clk);
      reset = 0;
      step(1, 511);
      chk("first_press_key", key_n, 0);
      chk("first_press_pulse", press_pulse, 1);
      for (int i = 0; i < 20; i++) step(1, 511);

      // asynchronous reset in the middle of a press
      do_reset();
      step(1, 511);
      chk("pre_reset_low", key_n, 0);
      #1 reset = 1;
      #1;
      chk("async_key_n", key_n, 1);
      chk("async_pulse", press_pulse, 0);
      chk("async_lfsr", lfsr_q, 0);
      model_reset();
      @(negedge clk);
      reset = 0;
      for (int i = 0; i < 8; i++) begin
         step(0, 0);
         chk("lfsr_seq", lfsr_q, seq[i]);
      end

      // enable dropped in the second press cycle, then held low
      do_reset();
      step(1, 511);
      step(1, 511);
      step(0, 511);
      chk("abort_key_n", key_n, 1);
      for (int i = 0; i < 12; i++) begin
         step(0, 511);
         chk("no_press_disabled", key_n, 1);
      end
      // enable dropped in the first press cycle
      step(1, 511);
      step(0, 511);
      for (int i = 0; i < 6; i++) step(1, 511);

      // difficulty 0 never presses
      do_reset();
      pulses = 0;
      for (int i = 0; i < 2048; i++) begin
         step(1, 0);
         if (press_pulse) pulses++;
      end
      chk("zero_diff_pulses", pulses, 0);

      // difficulty 300: run-length properties plus model
      do_reset();
      pulses = 0; low_runs = 0; run_len = 0; prev_key = 1; seen_low = 0;
      for (int i = 0; i < 10000; i++) begin
         step(1, 300);
         if (press_pulse) pulses++;
         if (key_n != prev_key) begin
            if (!prev_key) begin
               low_runs++;
               chk("low_run_len", run_len, HOLD);
            end else if (seen_low) begin
               chk("high_run_ge", run_len >= GAP + 1, 1);
            end
            if (!key_n) seen_low = 1;
            run_len = 1;
         end else run_len++;
         prev_key = key_n;
      end
      if (!key_n) low_runs++;
      chk("pulse_eq_runs", pulses, low_runs);
      chk("some_press", pulses > 0, 1);

      // randomized enable and difficulty
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         logic [8:0] d;
         d = 9'($urandom_range(0, 511));
         step(($urandom_range(0, 9) < 8), d);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
